// File: rtl/bf_pkg.sv
// Shared types and constants for the Brainfuck core memory bridge.
package bf_pkg;

    localparam int BF_AW = 8;
    localparam int BF_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_RUN   = 2'd3
    } bf_state_t;

    // Core bus phase, encoded as {addr, write}
    localparam logic [1:0] PH_READ   = 2'b00;
    localparam logic [1:0] PH_WRITE  = 2'b01;
    localparam logic [1:0] PH_ADDR   = 2'b10;
    localparam logic [1:0] PH_ADDR_W = 2'b11;

endpackage

// File: rtl/bf_ram256.sv
// 256x8 unified program/tape RAM: one synchronous write port, one asynchronous read port.
module bf_ram256
    import bf_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [BF_AW-1:0] waddr,
    input  logic [BF_DW-1:0] wdata,
    input  logic [BF_AW-1:0] raddr,
    output logic [BF_DW-1:0] rdata
);

    logic [BF_DW-1:0] mem [0:(1<<BF_AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bf_mem_bridge.sv
// Bus decoder and program loader for the Brainfuck core: loads RAM from a host
// stream, optionally zero-fills the tape, then releases the core and serves its bus.
module bf_mem_bridge
    import bf_pkg::*;
#(
    parameter int CLEAR_TAPE = 1,
    parameter int DEPTH      = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bus_write,
    input  logic             bus_addr,
    input  logic [BF_DW-1:0] bus_dout,
    output logic [BF_DW-1:0] bus_din,
    output logic             core_rst_n,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [BF_DW-1:0] load_data,
    input  logic             load_last,
    output logic             load_ready,
    output logic             running
);

    localparam logic [BF_AW-1:0] LAST_CELL = BF_AW'(DEPTH - 1);

    bf_state_t        state_reg;
    logic [BF_AW-1:0] load_ptr_reg;
    logic [BF_AW-1:0] addr_q_reg;
    logic             core_rst_n_reg;
    logic             load_ready_reg;

    logic             ram_we;
    logic [BF_AW-1:0] ram_waddr;
    logic [BF_DW-1:0] ram_wdata;
    logic [BF_DW-1:0] ram_rdata;
    logic [1:0]       phase;
    logic             handshake;

    assign phase     = {bus_addr, bus_write};
    assign handshake = load_valid & load_ready_reg;

    // Single RAM write port shared by loader, tape clear and core writes;
    // load_start and rst suppress every write in their cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = load_ptr_reg;
        ram_wdata = load_data;
        if (!rst && !load_start) begin
            case (state_reg)
                ST_LOAD:  ram_we = handshake;
                ST_CLEAR: begin
                    ram_we    = 1'b1;
                    ram_wdata = '0;
                end
                ST_RUN: begin
                    if (phase == PH_WRITE) begin
                        ram_we    = 1'b1;
                        ram_waddr = addr_q_reg;
                        ram_wdata = bus_dout;
                    end
                end
                default: ram_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            load_ptr_reg   <= '0;
            addr_q_reg     <= '0;
            core_rst_n_reg <= 1'b0;
            load_ready_reg <= 1'b0;
        end else if (load_start) begin
            state_reg      <= ST_LOAD;
            load_ptr_reg   <= '0;
            addr_q_reg     <= '0;
            core_rst_n_reg <= 1'b0;
            load_ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (handshake) begin
                        if (load_ptr_reg == LAST_CELL) begin
                            // RAM is full: implicit last byte, nothing left to clear
                            state_reg      <= ST_RUN;
                            core_rst_n_reg <= 1'b1;
                            load_ready_reg <= 1'b0;
                        end else begin
                            load_ptr_reg <= load_ptr_reg + 1'b1;
                            if (load_last) begin
                                load_ready_reg <= 1'b0;
                                if (CLEAR_TAPE != 0) begin
                                    state_reg <= ST_CLEAR;
                                end else begin
                                    state_reg      <= ST_RUN;
                                    core_rst_n_reg <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    if (load_ptr_reg == LAST_CELL) begin
                        state_reg      <= ST_RUN;
                        core_rst_n_reg <= 1'b1;
                    end else begin
                        load_ptr_reg <= load_ptr_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus_addr) begin
                        addr_q_reg <= bus_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    bf_ram256 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (addr_q_reg),
        .rdata (ram_rdata)
    );

    assign bus_din    = (state_reg == ST_RUN) ? ram_rdata : '0;
    assign core_rst_n = core_rst_n_reg;
    assign load_ready = load_ready_reg;
    assign running    = (state_reg == ST_RUN);

endmodule

// File: tb/tb_bf_mem_bridge.sv
// Self-checking bench: two bridges (tape clear on and off) share one stimulus and
// are compared against an array-based memory model.
module tb_bf_mem_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bus_write = 1'b0;
    logic       bus_addr = 1'b0;
    logic [7:0] bus_dout = '0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_last = 1'b0;

    logic [7:0] din1, din0;
    logic       crn1, crn0, rdy1, rdy0, run1, run0;

    always #5 clk = ~clk;

    bf_mem_bridge #(.CLEAR_TAPE(1), .DEPTH(256)) dut1 (
        .clk(clk), .rst(rst), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .bus_din(din1), .core_rst_n(crn1),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(rdy1), .running(run1)
    );

    bf_mem_bridge #(.CLEAR_TAPE(0), .DEPTH(256)) dut0 (
        .clk(clk), .rst(rst), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .bus_din(din0), .core_rst_n(crn0),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(rdy0), .running(run0)
    );

    // Reference model: memory image for each tape-clear setting plus the core address
    logic [7:0] m1 [256];
    logic [7:0] m0 [256];
    bit         k0 [256];
    logic [7:0] maddr;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       a;
        logic       w;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input logic a, input logic w, input logic [7:0] d);
        bus_addr  = a;
        bus_write = w;
        bus_dout  = d;
        step();
        if (a) begin
            maddr = d;
        end else if (w) begin
            m1[maddr] = d;
            m0[maddr] = d;
            k0[maddr] = 1'b1;
        end
        bus_addr  = 1'b0;
        bus_write = 1'b0;
    endtask

    task automatic check_din(input string nm);
        chk({nm, "_din1"}, din1, m1[maddr]);
        if (k0[maddr]) chk({nm, "_din0"}, din0, m0[maddr]);
    endtask

    task automatic readback_all(input string nm);
        for (int i = 0; i < 256; i++) begin
            bus_op(1'b1, 1'b0, 8'(i));
            check_din(nm);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        maddr = '0;
        chk("start_ready", rdy1, 1);
        chk("start_crn", crn1, 0);
    endtask

    // Streams bytes with random idle gaps; model applies loaded bytes then the tape clear
    task automatic load_prog(input logic [7:0] q[$], input bit use_last, input bit do_start);
        if (do_start) pulse_start();
        for (int i = 0; i < q.size(); i++) begin
            load_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            load_valid = 1'b1;
            load_data  = q[i];
            load_last  = use_last && (i == q.size() - 1);
            step();
            m1[i] = q[i];
            m0[i] = q[i];
            k0[i] = 1'b1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (use_last) begin
            for (int i = q.size(); i < 256; i++) m1[i] = 8'h00;
        end
    endtask

    task automatic wait_run();
        int c = 0;
        while (!(run1 && run0) && c < 400) begin
            step();
            c++;
        end
        chk("wait_run", int'(run1 && run0), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int         c;
        logic [7:0] hold_addr;

        for (int i = 0; i < 256; i++) begin
            m1[i] = '0;
            m0[i] = '0;
            k0[i] = 1'b0;
        end
        maddr = '0;

        // Reset values
        step();
        step();
        rst = 1'b0;
        chk("rst_crn1", crn1, 0);
        chk("rst_rdy1", rdy1, 0);
        chk("rst_run1", run1, 0);
        chk("rst_din1", din1, 0);
        chk("rst_run0", run0, 0);
        step();
        chk("idle_rdy1", rdy1, 0);
        chk("idle_crn1", crn1, 0);

        // Two-byte load with tape clear, core release timing
        q = '{8'h2B, 8'h2E};
        load_prog(q, 1'b1, 1'b1);
        chk("noclr_run0", run0, 1);
        chk("noclr_crn0", crn0, 1);
        chk("clr_rdy1", rdy1, 0);
        c = 0;
        while (!crn1 && c < 400) begin
            chk("clr_din1", din1, 0);
            step();
            c++;
        end
        chk("clear_cycles", c, 254);
        chk("clr_done_run1", run1, 1);
        readback_all("load2");

        // Table-driven bus sequence: apply phase, compare bus_din on the following cycle
        tbl[0] = '{1'b1, 1'b0, 8'h80, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h5A, 8'h5A};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 8'h5A};
        tbl[3] = '{1'b1, 1'b0, 8'h81, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 8'h2B};
        tbl[5] = '{1'b1, 1'b0, 8'h01, 8'h2E};
        tbl[6] = '{1'b1, 1'b1, 8'h80, 8'h5A};
        tbl[7] = '{1'b0, 1'b0, 8'hFF, 8'h5A};
        for (int i = 0; i < 8; i++) begin
            bus_op(tbl[i].a, tbl[i].w, tbl[i].d);
            chk($sformatf("tbl%0d", i), din1, tbl[i].exp);
        end

        // Same-cycle read and write returns the old value
        bus_write = 1'b1;
        bus_dout  = 8'h5B;
        #1;
        chk("same_old", din1, 8'h5A);
        step();
        m1[8'h80] = 8'h5B;
        m0[8'h80] = 8'h5B;
        k0[8'h80] = 1'b1;
        bus_write = 1'b0;
        chk("same_new", din1, 8'h5B);

        // Full 256-byte load without last: straight to RUN
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        load_prog(q, 1'b0, 1'b1);
        chk("full_run1", run1, 1);
        chk("full_crn1", crn1, 1);
        chk("full_rdy1", rdy1, 0);
        readback_all("full");

        // load_start overrides a handshake of 0x77 in LOAD
        pulse_start();
        load_valid = 1'b1;
        load_data  = 8'h11;
        step();
        m1[0] = 8'h11;
        m0[0] = 8'h11;
        load_data  = 8'h77;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b0;
        maddr = '0;
        chk("drop_rdy1", rdy1, 1);
        chk("drop_crn1", crn1, 0);
        chk("drop_din1", din1, 0);
        chk("drop_run1", run1, 0);
        q = '{8'hA0};
        load_prog(q, 1'b1, 1'b0);
        wait_run();
        bus_op(1'b1, 1'b0, 8'h00);
        check_din("drop_c0");
        bus_op(1'b1, 1'b0, 8'h01);
        check_din("drop_c1");

        // load_start during RUN suppresses a core write
        bus_op(1'b1, 1'b0, 8'h40);
        hold_addr  = maddr;
        bus_write  = 1'b1;
        bus_dout   = 8'h99;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        bus_write  = 1'b0;
        maddr = '0;
        chk("runstart_run1", run1, 0);
        chk("runstart_crn1", crn1, 0);
        chk("runstart_din1", din1, 0);
        chk("runstart_rdy1", rdy1, 1);
        q = '{8'h42};
        load_prog(q, 1'b1, 1'b0);
        wait_run();
        bus_op(1'b1, 1'b0, hold_addr);
        check_din("runstart_kept");

        // rst in RUN keeps RAM; reload one byte
        bus_op(1'b1, 1'b0, 8'h10);
        bus_op(1'b0, 1'b1, 8'h33);
        rst = 1'b1;
        step();
        rst = 1'b0;
        maddr = '0;
        chk("rst2_crn1", crn1, 0);
        chk("rst2_rdy1", rdy1, 0);
        chk("rst2_run1", run1, 0);
        chk("rst2_din1", din1, 0);
        chk("rst2_crn0", crn0, 0);
        chk("rst2_din0", din0, 0);
        q = '{8'h5C};
        load_prog(q, 1'b1, 1'b1);
        chk("rst2_run0", run0, 1);
        wait_run();
        bus_op(1'b1, 1'b0, 8'h10);
        check_din("rst2_keep");

        // Randomized loads followed by random bus traffic
        for (int r = 0; r < 5; r++) begin
            q = {};
            for (int i = 0; i < $urandom_range(1, 40); i++) q.push_back(8'($urandom));
            load_prog(q, 1'b1, 1'b1);
            wait_run();
            for (int t = 0; t < 150; t++) begin
                bus_op(($urandom % 3) == 0, 1'($urandom), 8'($urandom));
                check_din("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
